// File: rtl/sensor_app_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_app_pkg
// Description : Shared opcodes, ACK byte, FSM states and reply sizing for the
//               sensor application controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_app_pkg;

    localparam logic [7:0] c_op_read_count = 8'h30;
    localparam logic [7:0] c_op_clear      = 8'h31;
    localparam logic [7:0] c_op_version    = 8'h32;
    localparam logic [7:0] c_ack           = 8'hA0;
    localparam int         c_max_reply_len = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX     = 2'd1,
        ST_DECODE = 2'd2,
        ST_TX     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : sensor_event_counter
// Description : Saturating radiation event counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_event_counter #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hit,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] r_count;

    // A hit landing on the clear cycle is counted after the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= hit ? COUNT_WIDTH'(1) : '0;
        end else if (hit && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sensor_app_controller.sv
`default_nettype none
// ============================================================================
// Module      : sensor_app_controller
// Description : Single-byte command decoder and reply streamer for the
//               radiation sensor tag application layer.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_app_controller
    import sensor_app_pkg::*;
#(
    parameter int         COUNT_WIDTH = 32,
    parameter logic [7:0] VERSION     = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_soc,
    input  logic                   rx_eoc,
    input  logic                   rx_error,
    input  logic                   rx_data_valid,
    input  logic [7:0]             rx_data,
    input  logic                   resend_last,
    input  logic                   tx_req,
    output logic                   tx_data_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_last,
    input  logic                   hit,
    output logic [COUNT_WIDTH-1:0] count
);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_nbytes;
    logic        r_rx_err;
    logic [7:0]  r_first;
    logic [7:0]  r_buf [c_max_reply_len];
    logic [2:0]  r_buf_len;
    logic        r_pending;
    logic [1:0]  r_tx_idx;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic [7:0]  r_tx_data;

    logic [1:0]  w_nbytes;
    logic [7:0]  w_opcode;
    logic        w_frame_ok;
    logic        w_eoc;
    logic        w_clear;
    logic        w_accept;
    logic [1:0]  w_next_idx;
    logic [31:0] w_count32;

    // Byte count saturates at 2: anything beyond one byte is already invalid
    assign w_nbytes   = (rx_data_valid && (r_nbytes != 2'd2)) ? r_nbytes + 2'd1 : r_nbytes;
    assign w_opcode   = (r_nbytes == 2'd0) ? rx_data : r_first;
    assign w_frame_ok = (w_nbytes == 2'd1) && !(r_rx_err || rx_error);
    assign w_eoc      = (r_state == ST_RX) && rx_eoc && !rx_soc;
    assign w_clear    = w_eoc && !resend_last && w_frame_ok && (w_opcode == c_op_clear);
    assign w_accept   = r_tx_valid && tx_req;
    assign w_next_idx = r_tx_idx + 2'd1;

    always_comb begin
        w_count32                  = '0;
        w_count32[COUNT_WIDTH-1:0] = count;
    end

    sensor_event_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .hit  (hit),
        .clear(w_clear),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (rx_soc) w_state_next = ST_RX;
            ST_RX:     if (rx_soc) w_state_next = ST_RX;
                       else if (rx_eoc) w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = r_pending ? ST_TX : ST_IDLE;
            ST_TX:     if (rx_soc) w_state_next = ST_RX;
                       else if (w_accept && r_tx_last) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nbytes   <= '0;
            r_rx_err   <= 1'b0;
            r_first    <= '0;
            r_buf_len  <= '0;
            r_pending  <= 1'b0;
            r_tx_idx   <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
            for (int i = 0; i < c_max_reply_len; i++) r_buf[i] <= '0;
        end else begin
            if (rx_soc && (r_state != ST_DECODE)) begin
                r_nbytes <= '0;
                r_rx_err <= 1'b0;
            end else if (r_state == ST_RX) begin
                if (rx_data_valid) begin
                    if (r_nbytes == 2'd0) r_first <= rx_data;
                    r_nbytes <= w_nbytes;
                end
                if (rx_error) r_rx_err <= 1'b1;
            end

            // The reply buffer is only rewritten by a valid, non-resend frame
            if (w_eoc) begin
                if (resend_last) begin
                    r_pending <= (r_buf_len != 3'd0);
                end else if (w_frame_ok) begin
                    case (w_opcode)
                        c_op_read_count: begin
                            r_buf[0]  <= w_count32[31:24];
                            r_buf[1]  <= w_count32[23:16];
                            r_buf[2]  <= w_count32[15:8];
                            r_buf[3]  <= w_count32[7:0];
                            r_buf_len <= 3'd4;
                            r_pending <= 1'b1;
                        end
                        c_op_clear: begin
                            r_buf[0]  <= c_ack;
                            r_buf_len <= 3'd1;
                            r_pending <= 1'b1;
                        end
                        c_op_version: begin
                            r_buf[0]  <= VERSION;
                            r_buf_len <= 3'd1;
                            r_pending <= 1'b1;
                        end
                        default: r_pending <= 1'b0;
                    endcase
                end else begin
                    r_pending <= 1'b0;
                end
            end

            case (r_state)
                ST_DECODE: begin
                    if (r_pending) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= r_buf[0];
                        r_tx_last  <= (r_buf_len == 3'd1);
                        r_tx_idx   <= '0;
                    end
                end
                ST_TX: begin
                    if (rx_soc || (w_accept && r_tx_last)) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= '0;
                        r_tx_last  <= 1'b0;
                    end else if (w_accept) begin
                        r_tx_idx  <= w_next_idx;
                        r_tx_data <= r_buf[w_next_idx];
                        r_tx_last <= (({1'b0, r_tx_idx} + 3'd2) == r_buf_len);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data_valid = r_tx_valid;
    assign tx_data       = r_tx_data;
    assign tx_last       = r_tx_last;

endmodule
`default_nettype wire

// File: tb/tb_sensor_app_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_app_controller
// Description : Scoreboard bench for sensor_app_controller (32-bit and 8-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_app_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_soc = 1'b0, rx_eoc = 1'b0, rx_error = 1'b0, rx_data_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        resend_last = 1'b0, tx_req = 1'b0, hit = 1'b0, hit8 = 1'b0;
    logic        tx_data_valid, tx_last, tx_data_valid8, tx_last8;
    logic [7:0]  tx_data, tx_data8;
    logic [31:0] count;
    logic [7:0]  count8;

    logic [8:0]  q[$];
    logic [8:0]  q8[$];
    logic [8:0]  e, e8;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sensor_app_controller #(.COUNT_WIDTH(32), .VERSION(8'h5A)) dut (
        .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_error(rx_error),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data), .resend_last(resend_last),
        .tx_req(tx_req), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .tx_last(tx_last), .hit(hit), .count(count)
    );

    sensor_app_controller #(.COUNT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_error(rx_error),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data), .resend_last(resend_last),
        .tx_req(tx_req), .tx_data_valid(tx_data_valid8), .tx_data(tx_data8),
        .tx_last(tx_last8), .hit(hit8), .count(count8)
    );

    // Monitor: pops the expected {last,data} whenever a byte is accepted
    always @(negedge clk) begin
        if (!rst && tx_data_valid && tx_req) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h, required no byte", {tx_last, tx_data});
            end else begin
                e = q.pop_front();
                if ({tx_last, tx_data} !== e) begin
                    errors++;
                    $display("FAIL tx_byte: got %h, required %h", {tx_last, tx_data}, e);
                end
            end
        end
        if (!rst && tx_data_valid8 && tx_req && (q8.size() != 0)) begin
            checks++;
            e8 = q8.pop_front();
            if ({tx_last8, tx_data8} !== e8) begin
                errors++;
                $display("FAIL tx_byte8: got %h, required %h", {tx_last8, tx_data8}, e8);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [31:0] v, input logic [31:0] v8);
        for (int i = 3; i >= 0; i--) begin
            q.push_back({(i == 0), v[i*8 +: 8]});
            q8.push_back({(i == 0), v8[i*8 +: 8]});
        end
    endtask

    task automatic push1(input logic [7:0] b, input logic [7:0] b8);
        q.push_back({1'b1, b});
        q8.push_back({1'b1, b8});
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input bit err, input bit resend, input bit eoc_hit,
                              input bit expect_reply);
        rx_soc = 1'b1; tick(); rx_soc = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_valid = 1'b1;
            rx_data = (i == 0) ? b0 : b1;
            tick();
        end
        rx_data_valid = 1'b0;
        if (err) begin rx_error = 1'b1; tick(); rx_error = 1'b0; end
        rx_eoc = 1'b1; resend_last = resend; hit = eoc_hit;
        tick();
        rx_eoc = 1'b0; resend_last = 1'b0; hit = 1'b0;
        check("latency_eoc_plus1", tx_data_valid, 1'b0);
        tick();
        check("latency_eoc_plus2", tx_data_valid, expect_reply);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (q.size() == 0 && q8.size() == 0 && !tx_data_valid) done = 1'b1;
            else tick();
        end
        check("idle_timeout", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_count", count, 32'd0);
        check("rst_count8", count8, 32'd0);
        check("rst_tx_valid", tx_data_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_last", tx_last, 1'b0);
        rst = 1'b0;
        tx_req = 1'b1;

        // Saturation on the 8-bit instance
        hit8 = 1'b1; tick(300); hit8 = 1'b0;
        check("sat_count8", count8, 32'hFF);
        push4(32'd0, 32'h0000_00FF);
        send_frame(1, 8'h30, 8'h00, 0, 0, 0, 1);
        wait_idle();

        // READ_COUNT after 5 hits
        hit = 1'b1; tick(5); hit = 1'b0;
        check("count_5", count, 32'd5);
        push4(32'd5, 32'h0000_00FF);
        send_frame(1, 8'h30, 8'h00, 0, 0, 0, 1);
        wait_idle();

        // CLEAR with a coincident hit
        push1(8'hA0, 8'hA0);
        send_frame(1, 8'h31, 8'h00, 0, 0, 1, 1);
        wait_idle();
        check("clear_hit_count", count, 32'd1);
        check("clear_count8", count8, 32'd0);

        push1(8'h5A, 8'h01);
        send_frame(1, 8'h32, 8'h00, 0, 0, 0, 1);
        wait_idle();

        // Invalid frames: two bytes, unknown opcode, rx_error
        send_frame(2, 8'h30, 8'h00, 0, 0, 0, 0);
        tick(3); check("bad_len_quiet", tx_data_valid, 1'b0);
        send_frame(1, 8'h33, 8'h00, 0, 0, 0, 0);
        tick(3); check("bad_op_quiet", tx_data_valid, 1'b0);
        send_frame(1, 8'h30, 8'h00, 1, 0, 0, 0);
        tick(3); check("rx_err_quiet", tx_data_valid, 1'b0);

        // Resend keeps the earlier snapshot
        hit = 1'b1; tick(6); hit = 1'b0;
        check("count_7", count, 32'd7);
        push4(32'd7, 32'd0);
        send_frame(1, 8'h30, 8'h00, 0, 0, 0, 1);
        wait_idle();
        hit = 1'b1; tick(3); hit = 1'b0;
        push4(32'd7, 32'd0);
        send_frame(1, 8'h33, 8'h00, 0, 1, 0, 1);
        wait_idle();

        // Back-pressure on the last byte of a 4-byte reply
        push4(32'd10, 32'd0);
        send_frame(1, 8'h30, 8'h00, 0, 0, 0, 1);
        tick(3);
        tx_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_data", tx_data, 8'h0A);
            check("stall_last", tx_last, 1'b1);
            tick();
        end
        check("stall_valid", tx_data_valid, 1'b1);
        tx_req = 1'b1;
        wait_idle();

        // Abort on rx_soc during TX
        tx_req = 1'b0;
        send_frame(1, 8'h32, 8'h00, 0, 0, 0, 1);
        rx_soc = 1'b1; tick(); rx_soc = 1'b0;
        check("abort_valid", tx_data_valid, 1'b0);
        tx_req = 1'b1;
        push1(8'h5A, 8'h01);
        send_frame(1, 8'h32, 8'h00, 0, 0, 0, 1);
        wait_idle();

        // Reset mid-TX, then resend with an empty buffer
        tx_req = 1'b0;
        send_frame(1, 8'h32, 8'h00, 0, 0, 0, 1);
        rst = 1'b1; tick();
        check("rst_tx_valid2", tx_data_valid, 1'b0);
        check("rst_tx_data2", tx_data, 8'h00);
        check("rst_tx_last2", tx_last, 1'b0);
        check("rst_count2", count, 32'd0);
        rst = 1'b0;
        tx_req = 1'b1;
        send_frame(1, 8'h30, 8'h00, 0, 1, 0, 0);
        tick(3); check("resend_empty_quiet", tx_data_valid, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_app_controller.md
SENSOR_APP_CONTROLLER -- requirements
Module: sensor_app_controller

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32: width of the radiation event counter, legal range 8..32.
REQ-002 SHALL have parameter VERSION, default 8'h01: byte returned by the VERSION command.
REQ-003 SHALL have port clk, input, 1: 13.56MHz recovered carrier clock; the only clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_soc, input, 1: start of a received app frame.
REQ-006 SHALL have port rx_eoc, input, 1: end of a received app frame.
REQ-007 SHALL have port rx_error, input, 1: the current received frame is corrupt.
REQ-008 SHALL have port rx_data_valid, input, 1: rx_data holds a received byte, one-cycle strobe.
REQ-009 SHALL have port rx_data, input, 8: received byte.
REQ-010 SHALL have port resend_last, input, 1: pulse with rx_eoc asking for the previous reply to be repeated.
REQ-011 SHALL have port tx_req, input, 1: the ISO14443A core accepts the presented byte this cycle.
REQ-012 SHALL have port tx_data_valid, output, 1: a reply byte is presented.
REQ-013 SHALL have port tx_data, output, 8: reply byte.
REQ-014 SHALL have port tx_last, output, 1: the presented byte is the final reply byte.
REQ-015 SHALL have port hit, input, 1: one-cycle pulse per detected radiation event, already synchronous to clk.
REQ-016 SHALL have port count, output, COUNT_WIDTH: live event count for debug.

Function
REQ-017 SHALL increment count on each hit cycle, saturating at all-ones.
REQ-018 SHALL recognise these commands by the first byte of a frame: 8'h30 READ_COUNT, 8'h31 CLEAR, 8'h32 VERSION.
REQ-019 SHALL treat a frame as valid only if it has exactly 1 byte, no rx_error between rx_soc and rx_eoc, and a recognised opcode.
REQ-020 SHALL drop invalid frames silently: no reply, reply buffer unchanged.
REQ-021 SHALL, for READ_COUNT, snapshot count at rx_eoc and reply with 4 bytes, MSB first, zero-extended to 32 bits.
REQ-022 SHALL, for CLEAR, zero count at rx_eoc and reply with the 1 byte 8'hA0.
REQ-023 SHALL, when hit and a CLEAR take effect in the same cycle, leave count at 1.
REQ-024 SHALL, for VERSION, reply with the 1 byte VERSION.
REQ-025 SHALL, when resend_last is high at rx_eoc, re-send the stored reply buffer byte-identical, ignoring the frame contents.
REQ-026 SHALL, on resend with an empty buffer (no reply since reset), send nothing.
REQ-027 SHALL use a state machine with states IDLE, RX, DECODE and TX.
- IDLE to RX on rx_soc.
- RX to DECODE on rx_eoc.
- DECODE to TX when a reply exists, otherwise DECODE to IDLE.
- TX to IDLE when the tx_last byte is accepted.
REQ-028 SHALL assert tx_data_valid exactly 2 cycles after the cycle in which rx_eoc is high.
REQ-029 SHALL treat a byte as accepted when tx_data_valid and tx_req are both high; the next byte appears the following cycle.
REQ-030 SHALL hold tx_data and tx_last stable while tx_req is low.
REQ-031 SHALL, on rx_soc during TX, abort the reply: drop tx_data_valid next cycle and enter RX; the buffer is kept for resend.
REQ-032 SHALL, on rx_soc during RX, restart frame capture.
REQ-033 SHALL ignore rx_data_valid, rx_eoc and rx_error while in IDLE.

Reset
REQ-034 SHALL, on rst, set state to IDLE, count to 0, buffer to empty, and tx_data_valid, tx_data and tx_last to 0.
REQ-035 SHALL apply rst with priority over hit and over all rx inputs in the same cycle.

Structure
REQ-036 SHALL place opcode constants, the ACK constant 8'hA0, the state enum and the maximum reply length (4) in package sensor_app_pkg.
REQ-037 SHALL place the saturating counter in sub-module sensor_event_counter, with inputs hit and clear and output count; all other logic stays inline.

Verification
REQ-038 SHALL be checked with these directed scenarios:
- 5 hits, then frame {30} -> reply 00 00 00 05, tx_last on the 4th byte, first byte 2 cycles after eoc.
- Frame {31} with a hit in the same cycle as eoc -> reply A0, count = 1.
- Frame {32} with VERSION=8'h5A -> reply 5A; frames {30,00}, {33}, or {30} with rx_error -> no tx_data_valid.
- READ_COUNT reply (count=7), then 3 hits, then resend_last at eoc -> 00 00 00 07 again; resend right after rst -> nothing.
- tx_req held low 10 cycles mid-reply -> tx_data stable; rx_soc during TX -> tx_data_valid low next cycle.
- COUNT_WIDTH=8 with 300 hits, then {30} -> 00 00 00 FF; rst mid-TX -> all outputs 0 next cycle.
